cordic_postprocessing: RTL and testbench
========================================

Name: cordic_postprocessing

Overview:
- Inverse of the CORDIC preprocessing stage: restores full-circle results from the core's reduced-angle output.
- Quadrant flags {d1,d0} are queued when preprocessing issues an operand. They are popped when the iteration core delivers its result (Xr, Yr).
- The popped flags drive a quadrant remap with saturation and optional gain compensation.
- Output uses a valid/ready handshake toward downstream consumers.

Parameters:
- DEPTH, 16, tag FIFO entries; must be a power of 2 and at least the core's maximum number of results in flight.
- W, 16, X/Y data width, signed two's complement.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- tag_push  in  1  preprocessing issued an operand; capture d0/d1
- d0  in  1  quadrant flag: add pi/2 to the result angle
- d1  in  1  quadrant flag: add pi to the result angle
- tag_full  out  1  FIFO holds DEPTH entries
- core_valid  in  1  core result present this cycle (core has no backpressure)
- Xr  in  W  core X result
- Yr  in  W  core Y result
- Xout  out  W  corrected X
- Yout  out  W  corrected Y
- out_valid  out  1  Xout/Yout valid
- out_ready  in  1  downstream accepts
- err_ovf  out  1  sticky: tag push while full, or core result dropped due to stall
- err_unf  out  1  sticky: core_valid with FIFO empty

Behaviour:
- Reset (async, rst=1):
  - FIFO pointers and count = 0.
  - All pipeline valids = 0.
  - Xout = Yout = 0; out_valid = 0; err_ovf = err_unf = 0; tag_full = 0.
- Tag FIFO: synchronous, in-order. tag_full = (count == DEPTH).
  - Push when tag_push && !tag_full. A push while full is ignored and sets err_ovf.
  - Same-cycle push and pop are always legal, including when full: pop frees the slot and count is unchanged.
  - Pointers wrap modulo DEPTH.
- Pop occurs on every accepted core_valid.
  - If the FIFO is empty, the result is dropped, err_unf is set, and no output is produced.
- Stage A (registered) remap, applied in this order:
  - Step 1: if d0, (x,y) = (-Yr, Xr); otherwise (x,y) = (Xr, Yr).
  - Step 2: if d1, (x,y) = (-x, -y).
  - Every negation saturates: -(-2^(W-1)) = 2^(W-1)-1.
- Latency: core_valid in cycle N gives out_valid in cycle N+1 (N+2 with GAIN_COMP_EN), assuming no stall.
- Pipeline advance: a stage advances when the next stage is empty or draining. The output register drains when out_valid && out_ready.
  - With out_valid=1 and out_ready=0, Xout/Yout/out_valid hold stable.
  - If core_valid arrives while stage A is full and cannot advance, the result is dropped and err_ovf is set. Its tag is still popped to keep alignment.
- out_valid is cleared after a transfer unless new data moves in the same cycle. Back-to-back throughput is 1 per cycle while out_ready=1.
- err_ovf and err_unf clear only on rst.
- Reset mid-operation discards all in-flight results and queued tags immediately.

Optional Feature:
- Macro: GAIN_COMP_EN.
- Defined: adds stage B, which multiplies each of x and y by K = 0x4DBA (0.60725 in Q1.15).
  - Full 2W-bit signed product, add 2^14, arithmetic shift right 15, truncate to W.
  - No saturation is needed.
  - Latency is 2 cycles; stage B obeys the same stall rule.
- Undefined: stage B is absent, latency is 1 cycle, and outputs equal the stage A remap.

Test Plan:
- Remap, no gain, Xr=0x4000, Yr=0x1000, no stall:
  - push d1d0=00, core_valid → Xout=0x4000, Yout=0x1000 at N+1.
  - d1d0=01 → 0xF000, 0x4000.
  - d1d0=10 → 0xC000, 0xF000.
  - d1d0=11 → 0x1000, 0xC000.
- Saturation: d1d0=10, Xr=0x8000, Yr=0 → Xout=0x7FFF, Yout=0x0000.
- FIFO boundaries:
  - Push 16 tags → tag_full=1.
  - 17th push → err_ovf=1, count stays 16.
  - Simultaneous push and pop at full → count 16, no error.
  - core_valid with FIFO empty → err_unf=1, out_valid stays 0.
- Stall and order:
  - out_ready=0 with one result held → Xout/Yout stable over 5 cycles.
  - A second core_valid is captured in stage A.
  - A third core_valid → err_ovf=1.
  - out_ready=1 → the two held results emerge in order on consecutive cycles.
- Gain (GAIN_COMP_EN): d1d0=00, Xr=0x4000, Yr=0 → Xout=0x26DD, Yout=0x0000 at N+2.
- Reset mid-flight: assert rst with 3 tags queued and a result in stage A → all outputs and flags 0 asynchronously; first result after release uses only newly pushed tags.

Source files
------------

// File: rtl/cordic_postprocessing_if.sv
// Bundled handshake signals of the CORDIC post-processing stage: tag capture,
// core result delivery and the downstream valid/ready output.
interface cordic_postprocessing_if #(
   parameter int W = 16
);
   logic         tag_push;
   logic         d0;
   logic         d1;
   logic         tag_full;
   logic         core_valid;
   logic [W-1:0] Xr;
   logic [W-1:0] Yr;
   logic [W-1:0] Xout;
   logic [W-1:0] Yout;
   logic         out_valid;
   logic         out_ready;
   logic         err_ovf;
   logic         err_unf;

   modport master (
      output tag_push, d0, d1, core_valid, Xr, Yr, out_ready,
      input  tag_full, Xout, Yout, out_valid, err_ovf, err_unf
   );

   modport slave (
      input  tag_push, d0, d1, core_valid, Xr, Yr, out_ready,
      output tag_full, Xout, Yout, out_valid, err_ovf, err_unf
   );
endinterface

// File: rtl/cordic_postprocessing.sv
// CORDIC post-processing: quadrant tag FIFO, saturating remap and output skid.
// Define GAIN_COMP_EN to insert the K = 0.60725 gain-compensation stage.
module cordic_postprocessing #(
   parameter int DEPTH = 16,
   parameter int W     = 16
) (
   input logic                     clk,
   input logic                     rst,
   cordic_postprocessing_if.slave  bus
);
   localparam int           AW       = $clog2(DEPTH);
   localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]  ZERO_CNT = {(AW+1){1'b0}};
   localparam logic [AW:0]  ONE_CNT  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] ONE_PTR = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] SMAX     = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SMIN     = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] ONE_W    = {{(W-1){1'b0}}, 1'b1};

   function automatic logic [W-1:0] sat_neg(input logic [W-1:0] v);
      return (v == SMIN) ? SMAX : (~v + ONE_W);
   endfunction

   function automatic logic [2*W-1:0] remap(input logic [1:0] d,
                                            input logic [W-1:0] xr,
                                            input logic [W-1:0] yr);
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] t;
      if (d[0]) begin
         x = sat_neg(yr);
         y = xr;
      end else begin
         x = xr;
         y = yr;
      end
      if (d[1]) begin
         t = sat_neg(x);
         y = sat_neg(y);
         x = t;
      end else begin
         t = x;
      end
      return {x, y};
   endfunction

`ifdef GAIN_COMP_EN
   localparam logic [2*W-1:0] GAIN_K = {{(2*W-16){1'b0}}, 16'h4DBA};
   localparam logic [2*W-1:0] ROUND  = {{(2*W-15){1'b0}}, 15'h4000};

   // Q1.15 multiply with round-half-up; |K| < 1 so the result always fits W bits
   function automatic logic [W-1:0] gain(input logic [W-1:0] v);
      logic signed [2*W-1:0] p;
      p = $signed({{W{v[W-1]}}, v}) * $signed(GAIN_K);
      p = p + $signed(ROUND);
      return p[W+14:15];
   endfunction
`endif

   logic [1:0]    tag_mem_r [DEPTH];
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [AW:0]   count_r;
   logic          tag_full_r;
   logic          err_ovf_r;
   logic          err_unf_r;
   logic          a_valid_r;
   logic [W-1:0]  ax_r;
   logic [W-1:0]  ay_r;
   logic          out_valid_r;
   logic [W-1:0]  xout_r;
   logic [W-1:0]  yout_r;

   logic [AW:0]   count_nxt_s;
   logic          empty_s;
   logic          full_s;
   logic          pop_s;
   logic          push_s;
   logic          push_err_s;
   logic          out_free_s;
   logic          drop_s;
   logic [W-1:0]  rx_s;
   logic [W-1:0]  ry_s;
`ifdef GAIN_COMP_EN
   logic [W-1:0]  gx_s;
   logic [W-1:0]  gy_s;
`endif

   // FIFO status, handshake qualifiers and the combinational remap of the head tag
   always_comb begin
      empty_s     = (count_r == ZERO_CNT);
      full_s      = (count_r == FULL_CNT);
      pop_s       = bus.core_valid && !empty_s;
      push_s      = bus.tag_push && (!full_s || pop_s);
      push_err_s  = bus.tag_push && full_s && !pop_s;
      out_free_s  = !out_valid_r || bus.out_ready;
      drop_s      = pop_s && a_valid_r && !out_free_s;
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + ONE_CNT;
         2'b01:   count_nxt_s = count_r - ONE_CNT;
         default: count_nxt_s = count_r;
      endcase
      {rx_s, ry_s} = remap(tag_mem_r[rptr_r], bus.Xr, bus.Yr);
`ifdef GAIN_COMP_EN
      gx_s = gain(ax_r);
      gy_s = gain(ay_r);
`endif
   end

   // Tag storage; pointers and occupancy live in the reset domain below
   always_ff @(posedge clk) begin
      if (push_s) begin
         tag_mem_r[wptr_r] <= {bus.d1, bus.d0};
      end
   end

   // FIFO pointers, sticky errors and the stage A / output pipeline
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_r      <= {AW{1'b0}};
         rptr_r      <= {AW{1'b0}};
         count_r     <= ZERO_CNT;
         tag_full_r  <= 1'b0;
         err_ovf_r   <= 1'b0;
         err_unf_r   <= 1'b0;
         a_valid_r   <= 1'b0;
         ax_r        <= {W{1'b0}};
         ay_r        <= {W{1'b0}};
         out_valid_r <= 1'b0;
         xout_r      <= {W{1'b0}};
         yout_r      <= {W{1'b0}};
      end else begin
         if (push_s) begin
            wptr_r <= wptr_r + ONE_PTR;
         end
         if (pop_s) begin
            rptr_r <= rptr_r + ONE_PTR;
         end
         count_r    <= count_nxt_s;
         tag_full_r <= (count_nxt_s == FULL_CNT);
         if (push_err_s || drop_s) begin
            err_ovf_r <= 1'b1;
         end
         if (bus.core_valid && empty_s) begin
            err_unf_r <= 1'b1;
         end

         if (out_free_s) begin
`ifdef GAIN_COMP_EN
            out_valid_r <= a_valid_r;
            if (a_valid_r) begin
               xout_r <= gx_s;
               yout_r <= gy_s;
            end
            a_valid_r <= pop_s;
            if (pop_s) begin
               ax_r <= rx_s;
               ay_r <= ry_s;
            end
`else
            // Stage A only holds data while the output is stalled; otherwise bypass it
            if (a_valid_r) begin
               out_valid_r <= 1'b1;
               xout_r      <= ax_r;
               yout_r      <= ay_r;
               a_valid_r   <= pop_s;
               if (pop_s) begin
                  ax_r <= rx_s;
                  ay_r <= ry_s;
               end
            end else begin
               out_valid_r <= pop_s;
               if (pop_s) begin
                  xout_r <= rx_s;
                  yout_r <= ry_s;
               end
            end
`endif
         end else if (pop_s && !a_valid_r) begin
            a_valid_r <= 1'b1;
            ax_r      <= rx_s;
            ay_r      <= ry_s;
         end
      end
   end

   assign bus.tag_full  = tag_full_r;
   assign bus.Xout      = xout_r;
   assign bus.Yout      = yout_r;
   assign bus.out_valid = out_valid_r;
   assign bus.err_ovf   = err_ovf_r;
   assign bus.err_unf   = err_unf_r;

endmodule

// File: tb/tb_cordic_postprocessing.sv
// Self-checking bench for cordic_postprocessing: directed boundary steps plus a
// randomized phase scored against a plain-arithmetic reference model.
module tb_cordic_postprocessing;
`ifdef GAIN_COMP_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   outstanding = 0;
   logic [1:0]  tagq [$];
   logic [31:0] expq [$];

   cordic_postprocessing_if #(.W(16)) bus();

   cordic_postprocessing #(.DEPTH(16), .W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic int sneg(input int v);
      return (v == -32768) ? 32767 : -v;
   endfunction

   // Expected {Xout,Yout}: rotate by d0*pi/2 then d1*pi with saturating negation
   function automatic logic [31:0] ref_out(input logic [1:0] d, input logic [15:0] xr, input logic [15:0] yr);
      int x;
      int y;
      int t;
      x = $signed(xr);
      y = $signed(yr);
      if (d[0]) begin
         t = x;
         x = sneg(y);
         y = t;
      end
      if (d[1]) begin
         x = sneg(x);
         y = sneg(y);
      end
`ifdef GAIN_COMP_EN
      x = int'((longint'(x) * 64'sd19898 + 64'sd16384) >>> 15);
      y = int'((longint'(y) * 64'sd19898 + 64'sd16384) >>> 15);
`endif
      return {x[15:0], y[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic tp, input logic [1:0] d, input logic cv,
                      input logic [15:0] xr, input logic [15:0] yr, input logic rdy);
      bus.tag_push   = tp;
      bus.d0         = d[0];
      bus.d1         = d[1];
      bus.core_valid = cv;
      bus.Xr         = xr;
      bus.Yr         = yr;
      bus.out_ready  = rdy;
      @(negedge clk);
   endtask

   // One cycle with scoreboarding: check any transfer, then update the tag/result model
   task automatic sc(input logic tp, input logic [1:0] d, input logic cv,
                     input logic [15:0] xr, input logic [15:0] yr, input logic rdy);
      logic [31:0] e;
      if ((bus.out_valid === 1'b1) && rdy) begin
         if (expq.size() == 0) begin
            chk1("sc_spurious_valid", bus.out_valid, 1'b0);
         end else begin
            e = expq.pop_front();
            chk("sc_data", {bus.Xout, bus.Yout}, e);
         end
         if (outstanding > 0) outstanding--;
      end
      if (cv && (tagq.size() > 0)) begin
         expq.push_back(ref_out(tagq.pop_front(), xr, yr));
         outstanding++;
      end
      if (tp && (tagq.size() < 16)) tagq.push_back(d);
      cyc(tp, d, cv, xr, yr, rdy);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.tag_push = 1'b0; bus.d0 = 1'b0; bus.d1 = 1'b0; bus.core_valid = 1'b0;
      bus.Xr = 16'h0000; bus.Yr = 16'h0000; bus.out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      tagq.delete();
      expq.delete();
      outstanding = 0;
   endtask

   task automatic idle(input logic rdy);
      cyc(1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, rdy);
   endtask

   initial begin
      logic [1:0]  dtab [5];
      logic [15:0] xtab [5];
      logic [15:0] ytab [5];
      logic [31:0] held;
      dtab = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
      xtab = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h8000};
      ytab = '{16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h0000};

      // Reset state
      rst = 1'b1;
      bus.tag_push = 1'b0; bus.d0 = 1'b0; bus.d1 = 1'b0; bus.core_valid = 1'b0;
      bus.Xr = 16'h0000; bus.Yr = 16'h0000; bus.out_ready = 1'b0;
      @(negedge clk);
      chk("rst_xy", {bus.Xout, bus.Yout}, 32'h0000_0000);
      chk1("rst_valid", bus.out_valid, 1'b0);
      chk1("rst_full", bus.tag_full, 1'b0);
      chk1("rst_ovf", bus.err_ovf, 1'b0);
      chk1("rst_unf", bus.err_unf, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Quadrant remap and saturation, latency LAT
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, dtab[i], 1'b0, 16'h0000, 16'h0000, 1'b1);
         cyc(1'b0, 2'b00, 1'b1, xtab[i], ytab[i], 1'b1);
         repeat (LAT - 1) idle(1'b1);
         chk1("remap_valid", bus.out_valid, 1'b1);
         chk("remap_data", {bus.Xout, bus.Yout}, ref_out(dtab[i], xtab[i], ytab[i]));
      end
      idle(1'b1);
      chk1("valid_clears", bus.out_valid, 1'b0);
`ifdef GAIN_COMP_EN
      cyc(1'b1, 2'b00, 1'b0, 16'h0000, 16'h0000, 1'b1);
      cyc(1'b0, 2'b00, 1'b1, 16'h4000, 16'h0000, 1'b1);
      idle(1'b1);
      chk("gain_k", {bus.Xout, bus.Yout}, 32'h26DD_0000);
      idle(1'b1);
`endif

      // Randomized traffic with backpressure, never overrunning the two result slots
      for (int i = 0; i < 400; i++) begin
         logic tp;
         logic cv;
         logic rdy;
         logic [1:0]  d;
         logic [15:0] xr;
         logic [15:0] yr;
         d   = 2'($urandom_range(0, 3));
         xr  = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
         yr  = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
         rdy = ($urandom_range(0, 3) != 0);
         tp  = ($urandom_range(0, 1) == 1) && (tagq.size() < 16);
         cv  = ($urandom_range(0, 1) == 1) && (tagq.size() > 0) && (outstanding < 2);
         sc(tp, d, cv, xr, yr, rdy);
      end
      for (int k = 0; (k < 10) && (expq.size() > 0); k++) sc(1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 1'b1);
      chk("rand_drain_left", 32'(expq.size()), 32'd0);
      chk1("rand_no_ovf", bus.err_ovf, 1'b0);
      chk1("rand_no_unf", bus.err_unf, 1'b0);

      // FIFO boundaries: fill, swap at full, overflow push, drain, underflow
      do_reset();
      for (int i = 0; i < 16; i++) begin
         sc(1'b1, 2'(i % 4), 1'b0, 16'h0000, 16'h0000, 1'b1);
         chk1("fifo_fill_full", bus.tag_full, (i == 15));
      end
      chk1("fifo_fill_noerr", bus.err_ovf, 1'b0);
      sc(1'b1, 2'b11, 1'b1, 16'h1234, 16'h8000, 1'b1);
      chk1("fifo_swap_full", bus.tag_full, 1'b1);
      chk1("fifo_swap_noerr", bus.err_ovf, 1'b0);
      sc(1'b1, 2'b01, 1'b0, 16'h0000, 16'h0000, 1'b1);
      chk1("fifo_push_full_err", bus.err_ovf, 1'b1);
      chk1("fifo_push_full_stay", bus.tag_full, 1'b1);
      for (int i = 0; i < 16; i++) begin
         sc(1'b0, 2'b00, 1'b1, 16'($urandom), 16'($urandom), 1'b1);
         if (i == 0) chk1("fifo_pop_notfull", bus.tag_full, 1'b0);
      end
      for (int k = 0; (k < 10) && (expq.size() > 0); k++) sc(1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 1'b1);
      chk("fifo_drain_left", 32'(expq.size()), 32'd0);
      chk1("fifo_no_unf_yet", bus.err_unf, 1'b0);
      sc(1'b0, 2'b00, 1'b1, 16'h5555, 16'h2222, 1'b1);
      chk1("unf_flag", bus.err_unf, 1'b1);
      for (int k = 0; k < LAT; k++) begin
         chk1("unf_no_out", bus.out_valid, 1'b0);
         sc(1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 1'b1);
      end

      // Stall: hold, capture a second result, drop a third, release in order
      do_reset();
      cyc(1'b1, 2'b01, 1'b0, 16'h0000, 16'h0000, 1'b0);
      cyc(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0000, 1'b0);
      cyc(1'b1, 2'b11, 1'b0, 16'h0000, 16'h0000, 1'b0);
      cyc(1'b0, 2'b00, 1'b1, 16'h1111, 16'h2222, 1'b0);
      repeat (LAT - 1) idle(1'b0);
      chk1("stall_valid", bus.out_valid, 1'b1);
      held = {bus.Xout, bus.Yout};
      chk("stall_first", held, ref_out(2'b01, 16'h1111, 16'h2222));
      for (int k = 0; k < 5; k++) begin
         idle(1'b0);
         chk("stall_hold", {bus.Xout, bus.Yout}, held);
         chk1("stall_hold_valid", bus.out_valid, 1'b1);
      end
      cyc(1'b0, 2'b00, 1'b1, 16'h3333, 16'h4444, 1'b0);
      repeat (LAT - 1) idle(1'b0);
      chk1("stall_second_noerr", bus.err_ovf, 1'b0);
      chk("stall_hold2", {bus.Xout, bus.Yout}, held);
      cyc(1'b0, 2'b00, 1'b1, 16'h5555, 16'h6666, 1'b0);
      chk1("stall_third_ovf", bus.err_ovf, 1'b1);
      chk("stall_hold3", {bus.Xout, bus.Yout}, held);
      idle(1'b1);
      chk1("release_valid2", bus.out_valid, 1'b1);
      chk("release_second", {bus.Xout, bus.Yout}, ref_out(2'b10, 16'h3333, 16'h4444));
      idle(1'b1);
      chk1("release_empty", bus.out_valid, 1'b0);

      // Reset mid-flight with queued tags and a held result
      for (int k = 0; k < 5; k++) cyc(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0000, 1'b0);
      cyc(1'b0, 2'b00, 1'b1, 16'h0100, 16'h0200, 1'b0);
      cyc(1'b0, 2'b00, 1'b1, 16'h0300, 16'h0400, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_xy", {bus.Xout, bus.Yout}, 32'h0000_0000);
      chk1("mid_rst_valid", bus.out_valid, 1'b0);
      chk1("mid_rst_full", bus.tag_full, 1'b0);
      chk1("mid_rst_ovf", bus.err_ovf, 1'b0);
      chk1("mid_rst_unf", bus.err_unf, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      cyc(1'b1, 2'b01, 1'b0, 16'h0000, 16'h0000, 1'b1);
      cyc(1'b0, 2'b00, 1'b1, 16'h4000, 16'h1000, 1'b1);
      repeat (LAT - 1) idle(1'b1);
      chk1("post_rst_valid", bus.out_valid, 1'b1);
      chk("post_rst_data", {bus.Xout, bus.Yout}, ref_out(2'b01, 16'h4000, 16'h1000));
      chk1("post_rst_noerr", bus.err_unf, 1'b0);
      cyc(1'b0, 2'b00, 1'b1, 16'h4000, 16'h1000, 1'b1);
      chk1("post_rst_old_tags_gone", bus.err_unf, 1'b1);
      idle(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
